// File: rtl/regfile_dbg.sv
// Parametrised register file with write-to-read bypass, optional hard-wired zero
// register and a valid/ready engine that streams every register out for debug.
module regfile_dbg #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] I_REGFILE_RS,
    input  logic [ADDR_W-1:0] I_REGFILE_RT,
    input  logic [ADDR_W-1:0] I_REGFILE_RD,
    input  logic [DATA_W-1:0] I_REGFILE_WRITE_DATA,
    input  logic              I_REGFILE_REGWR,
    output logic [DATA_W-1:0] O_REGFILE_READ_DATA1,
    output logic [DATA_W-1:0] O_REGFILE_READ_DATA2,
    input  logic              I_DBG_START,
    input  logic              I_DBG_READY,
    output logic              O_DBG_VALID,
    output logic [ADDR_W-1:0] O_DBG_ADDR,
    output logic [DATA_W-1:0] O_DBG_DATA,
    output logic              O_DBG_BUSY,
    output logic              O_DBG_DONE
);

    localparam int                NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              write_en;
    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] data_q;
    logic              load_first;
    logic              advance;
    logic [ADDR_W-1:0] capture_addr;

    // Shared by both read ports and the dump capture so all three see a WB write the same way.
    function automatic logic [DATA_W-1:0] bypass_read(input logic [ADDR_W-1:0] addr);
        if ((ZERO_REG != 0) && (addr == '0))
            return '0;
        else if (I_REGFILE_REGWR && (I_REGFILE_RD == addr))
            return I_REGFILE_WRITE_DATA;
        else
            return regs[addr];
    endfunction

    assign write_en = I_REGFILE_REGWR && !((ZERO_REG != 0) && (I_REGFILE_RD == '0));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (write_en) begin
            regs[I_REGFILE_RD] <= I_REGFILE_WRITE_DATA;
        end
    end

    assign O_REGFILE_READ_DATA1 = bypass_read(I_REGFILE_RS);
    assign O_REGFILE_READ_DATA2 = bypass_read(I_REGFILE_RT);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        load_first  = 1'b0;
        advance     = 1'b0;
        O_DBG_VALID = 1'b0;
        O_DBG_BUSY  = 1'b0;
        O_DBG_DONE  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_DBG_START) begin
                    load_first = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                O_DBG_VALID = 1'b1;
                O_DBG_BUSY  = 1'b1;
                if (I_DBG_READY) begin
                    if (idx_q == LAST_IDX)
                        state_d = ST_DONE;
                    else
                        advance = 1'b1;
                end
            end
            ST_DONE: begin
                O_DBG_BUSY = 1'b1;
                O_DBG_DONE = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture happens only on start or an accepted beat, so ADDR/DATA hold through stalls.
    assign capture_addr = load_first ? '0 : idx_q + 1'b1;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            idx_q  <= '0;
            data_q <= '0;
        end else if (load_first || advance) begin
            idx_q  <= capture_addr;
            data_q <= bypass_read(capture_addr);
        end
    end

    assign O_DBG_ADDR = idx_q;
    assign O_DBG_DATA = data_q;

endmodule

// File: doc/regfile_dbg.md
Name: regfile_dbg

Overview:
- Parametrised successor to the CPU general-purpose register file.
- Generalised data width and depth, optional hard-wired zero register, and write-to-read bypass so an ID-stage read sees a same-cycle WB write.
- Replaces the 32 flat debug register outputs with a streaming valid/ready dump engine, for the debug/UART unit to read the register contents serially.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is an ordinary register

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET_N  in  1  asynchronous active-low reset
- I_REGFILE_RS  in  ADDR_W  read port 1 address
- I_REGFILE_RT  in  ADDR_W  read port 2 address
- I_REGFILE_RD  in  ADDR_W  write address
- I_REGFILE_WRITE_DATA  in  DATA_W  write data
- I_REGFILE_REGWR  in  1  write enable
- O_REGFILE_READ_DATA1  out  DATA_W  read data, port 1 (combinational)
- O_REGFILE_READ_DATA2  out  DATA_W  read data, port 2 (combinational)
- I_DBG_START  in  1  start-dump pulse
- I_DBG_READY  in  1  consumer ready
- O_DBG_VALID  out  1  O_DBG_ADDR/O_DBG_DATA valid
- O_DBG_ADDR  out  ADDR_W  index of the register being dumped
- O_DBG_DATA  out  DATA_W  value of the register being dumped
- O_DBG_BUSY  out  1  dump in progress
- O_DBG_DONE  out  1  one-cycle pulse after the last beat

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - all registers cleared to 0
  - FSM goes to IDLE
  - O_DBG_VALID, O_DBG_BUSY, O_DBG_DONE, O_DBG_ADDR and O_DBG_DATA all 0
  - read outputs show 0 because the array is 0
- Write: on the rising edge when REGWR=1, REG[RD] <= WRITE_DATA. When ZERO_REG=1 and RD=0, the write is dropped.
- Read (combinational, each port independently):
  - if ZERO_REG=1 and the address is 0, output 0
  - else if REGWR=1 and RD equals the read address, output WRITE_DATA (bypass)
  - else output REG[address]
  - Both ports may bypass in the same cycle.
- FSM states: IDLE, SEND, DONE.
  - IDLE: BUSY=0, VALID=0. When I_DBG_START=1:
    - idx <= 0
    - capture DATA from the bypassed read of address 0
    - go to SEND
  - SEND: BUSY=1, VALID=1, ADDR=idx, DATA=captured value.
    - ADDR and DATA stay stable while VALID=1 and READY=0.
    - On VALID and READY with idx < NUM_REGS-1: idx <= idx+1, capture the bypassed read of idx+1, remain in SEND. Back-to-back beats run at 1 per cycle.
    - On VALID and READY with idx = NUM_REGS-1: go to DONE.
  - DONE: BUSY=1, VALID=0, DONE=1 for exactly one cycle, then go to IDLE.
- The dump has lowest priority and never stalls or blocks normal reads or writes.
- Capture uses the same bypass rule as the read ports, so a write in the capture cycle is reflected in the captured data.
- A write to an already-captured or already-sent index is not reflected in that beat.
- I_DBG_START is ignored outside IDLE.
- RESET_N asserted mid-dump aborts the dump immediately with no DONE pulse.
- Exactly NUM_REGS beats per dump, in ascending address order. No wrap; the index counter never exceeds NUM_REGS-1.

Test Plan:
- Reset, then write R5=0xDEADBEEF, read RS=5 the next cycle -> READ_DATA1=0xDEADBEEF. Read RT=6 -> 0.
- Same cycle: REGWR=1, RD=7, WRITE_DATA=0x12345678, RS=7, RT=7 -> both outputs 0x12345678 in that cycle. R7 holds it afterwards.
- ZERO_REG=1: write RD=0 with 0xFFFFFFFF, RS=0 in the same and next cycle -> 0. Rerun with ZERO_REG=0 -> 0xFFFFFFFF from the next cycle and via bypass.
- Load R[i]=i*3, START, READY held at 1 -> 32 consecutive beats with ADDR 0..31 and DATA 0,3,..,93. DONE pulses for 1 cycle immediately after the last beat. BUSY covers the start through DONE.
- Dump with READY toggled randomly, plus a write R10=0xAA while ADDR=10 is stalled -> beat 10 keeps its old data and ADDR/DATA stay stable during the stall. A write R20=0xBB before beat 20 is captured -> beat 20 shows 0xBB. START pulsed mid-dump -> no restart.
- Assert RESET_N=0 at beat 12 of a dump -> VALID/BUSY drop to 0 asynchronously, no DONE pulse, all registers read 0 after reset release. A new START then gives a full 32-beat dump of zeros.
